// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
//   Elastic pipeline stage register carrying an opaque WIDTH-bit payload between two stages
//   with valid/ready handshaking. With SKID=1 a second (skid) entry absorbs one beat of
//   back-pressure so in_ready is a pure register decode. With SKID=0 it is a single entry
//   whose in_ready looks through to out_ready. A flush squashes all held entries. Two
//   saturating statistics counters track stall cycles and squashed entries.
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   flush                 synchronous squash of all held entries
//   in_valid/in_ready     upstream handshake, in_data payload
//   out_valid/out_ready   downstream handshake, out_data registered head payload
//   occupancy             entries held (0..2)
//   clr_stats             synchronous clear of both counters
//   stall_cnt             cycles with out_valid & ~out_ready, saturating
//   squash_cnt            valid entries discarded by flush, saturating
module pipe_stage_elastic #(
  parameter int unsigned      WIDTH      = 32,
  parameter bit               SKID       = 1'b1,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = WIDTH'(32'h00000013),
  parameter int unsigned      CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] squash_cnt
);

  typedef enum logic [1:0] {
    StEmpty    = 2'd0,
    StFull     = 2'd1,
    StSkidFull = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_main, w_main_d;
  logic [WIDTH-1:0] r_skid, w_skid_d;
  logic [CNT_W-1:0] r_stall, w_stall_d;
  logic [CNT_W-1:0] r_squash, w_squash_d;

  logic             w_skid_full;
  logic             w_in_fire;
  logic             w_out_fire;
  logic [1:0]       w_sq_amt;
  logic [CNT_W:0]   w_sq_sum;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StEmpty;
      r_main   <= BUBBLE_VAL;
      r_skid   <= BUBBLE_VAL;
      r_stall  <= '0;
      r_squash <= '0;
    end else begin
      r_state  <= w_state_d;
      r_main   <= w_main_d;
      r_skid   <= w_skid_d;
      r_stall  <= w_stall_d;
      r_squash <= w_squash_d;
    end
  end

  // Output decode
  always_comb begin
    out_valid   = 1'b0;
    occupancy   = 2'd0;
    w_skid_full = 1'b0;
    case (r_state)
      StFull: begin
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      StSkidFull: begin
        out_valid   = 1'b1;
        occupancy   = 2'd2;
        w_skid_full = 1'b1;
      end
      default: ;
    endcase
    // Skid build keeps in_ready free of any path from out_ready.
    if (SKID) begin
      in_ready = ~w_skid_full & ~flush;
    end else begin
      in_ready = (out_ready | ~out_valid) & ~flush;
    end
  end

  assign out_data   = r_main;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // Next state and payload
  always_comb begin
    w_state_d = r_state;
    w_main_d  = r_main;
    w_skid_d  = r_skid;
    if (flush) begin
      w_state_d = StEmpty;
      w_main_d  = BUBBLE_VAL;
      w_skid_d  = BUBBLE_VAL;
    end else begin
      case (r_state)
        StEmpty: begin
          if (w_in_fire) begin
            w_state_d = StFull;
            w_main_d  = in_data;
          end
        end
        StFull: begin
          if (w_in_fire && w_out_fire) begin
            w_main_d = in_data;
          end else if (w_in_fire && SKID) begin
            w_state_d = StSkidFull;
            w_skid_d  = in_data;
          end else if (w_out_fire) begin
            w_state_d = StEmpty;
            w_main_d  = BUBBLE_VAL;
          end
        end
        StSkidFull: begin
          if (w_out_fire) begin
            w_state_d = StFull;
            w_main_d  = r_skid;
            w_skid_d  = BUBBLE_VAL;
          end
        end
        default: w_state_d = StEmpty;
      endcase
    end
  end

  // Statistics counters; clear wins over increment
  always_comb begin
    // A head consumed during the flush cycle is delivered, not squashed.
    w_sq_amt = flush ? (occupancy - {1'b0, w_out_fire}) : 2'd0;
    w_sq_sum = {1'b0, r_squash} + {{(CNT_W - 1){1'b0}}, w_sq_amt};

    if (clr_stats) begin
      w_stall_d = '0;
    end else if (out_valid && !out_ready && (r_stall != CntMax)) begin
      w_stall_d = r_stall + CNT_W'(1);
    end else begin
      w_stall_d = r_stall;
    end

    if (clr_stats) begin
      w_squash_d = '0;
    end else if (w_sq_sum[CNT_W]) begin
      w_squash_d = CntMax;
    end else begin
      w_squash_d = w_sq_sum[CNT_W-1:0];
    end
  end

  assign stall_cnt  = r_stall;
  assign squash_cnt = r_squash;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic
//   Drives three builds of pipe_stage_elastic from shared stimulus:
//     0: SKID=1, CNT_W=16   1: SKID=0, CNT_W=16   2: SKID=1, CNT_W=4
//   Each build is compared every cycle against a queue-style reference model.
module tb_pipe_stage_elastic;

  localparam logic [31:0] Bubble = 32'h00000013;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        clr_stats;

  logic        o_rdy [3];
  logic        o_ov  [3];
  logic [31:0] o_od  [3];
  logic [1:0]  o_occ [3];
  logic [15:0] o_st  [3];
  logic [15:0] o_sq  [3];
  logic [3:0]  st_narrow, sq_narrow;

  int total = 0;
  int bad   = 0;

  // Reference model: up to two accepted beats in acceptance order
  logic [31:0] m_ent  [3][2];
  int          m_n    [3];
  int          m_st   [3];
  int          m_sq   [3];
  int          m_max  [3] = '{65535, 65535, 15};
  bit          m_skid [3] = '{1'b1, 1'b0, 1'b1};

  pipe_stage_elastic #(.WIDTH(32), .SKID(1'b1), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(o_rdy[0]), .in_data(in_data),
    .out_valid(o_ov[0]), .out_ready(out_ready), .out_data(o_od[0]),
    .occupancy(o_occ[0]), .clr_stats(clr_stats),
    .stall_cnt(o_st[0]), .squash_cnt(o_sq[0])
  );

  pipe_stage_elastic #(.WIDTH(32), .SKID(1'b0), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(o_rdy[1]), .in_data(in_data),
    .out_valid(o_ov[1]), .out_ready(out_ready), .out_data(o_od[1]),
    .occupancy(o_occ[1]), .clr_stats(clr_stats),
    .stall_cnt(o_st[1]), .squash_cnt(o_sq[1])
  );

  pipe_stage_elastic #(.WIDTH(32), .SKID(1'b1), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(o_rdy[2]), .in_data(in_data),
    .out_valid(o_ov[2]), .out_ready(out_ready), .out_data(o_od[2]),
    .occupancy(o_occ[2]), .clr_stats(clr_stats),
    .stall_cnt(st_narrow), .squash_cnt(sq_narrow)
  );

  assign o_st[2] = {12'd0, st_narrow};
  assign o_sq[2] = {12'd0, sq_narrow};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", tag, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      m_n[k]  = 0;
      m_st[k] = 0;
      m_sq[k] = 0;
    end
  endtask

  function automatic bit exp_ready(input int k);
    if (flush) return 1'b0;
    if (m_skid[k]) return (m_n[k] < 2);
    return out_ready || (m_n[k] == 0);
  endfunction

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("d%0d_in_ready", k), 32'(o_rdy[k]), 32'(exp_ready(k)));
      check($sformatf("d%0d_out_valid", k), 32'(o_ov[k]), 32'(m_n[k] > 0));
      check($sformatf("d%0d_out_data", k), o_od[k], (m_n[k] > 0) ? m_ent[k][0] : Bubble);
      check($sformatf("d%0d_occupancy", k), 32'(o_occ[k]), m_n[k]);
      check($sformatf("d%0d_stall_cnt", k), 32'(o_st[k]), m_st[k]);
      check($sformatf("d%0d_squash_cnt", k), 32'(o_sq[k]), m_sq[k]);
    end
  endtask

  // Advance the model by one clock using the inputs held across the edge.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit in_fire, out_fire;
      in_fire  = in_valid && exp_ready(k);
      out_fire = (m_n[k] > 0) && out_ready;
      if (clr_stats) begin
        m_st[k] = 0;
        m_sq[k] = 0;
      end else begin
        if ((m_n[k] > 0) && !out_ready && (m_st[k] < m_max[k])) m_st[k]++;
        if (flush) begin
          m_sq[k] = m_sq[k] + m_n[k] - int'(out_fire);
          if (m_sq[k] > m_max[k]) m_sq[k] = m_max[k];
        end
      end
      if (flush) begin
        m_n[k] = 0;
      end else begin
        if (out_fire) begin
          m_ent[k][0] = m_ent[k][1];
          m_n[k]--;
        end
        if (in_fire) begin
          m_ent[k][m_n[k]] = in_data;
          m_n[k]++;
        end
      end
    end
  endtask

  task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy,
                       input logic fl, input logic clr);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    clr_stats = clr;
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (rst) model_clear();
    else model_step();
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    clr_stats = 1'b0;
    model_clear();
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Async reset while holding two entries
    cycle(1'b1, 32'hA0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hB0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("pre_rst_occ", 32'(o_occ[0]), 32'd2);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    check_all();
    check("rst_out_data", o_od[0], Bubble);
    #1;
    rst = 1'b0;
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Streaming 1..100
    for (int i = 1; i <= 100; i++) cycle(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("stream_stall", 32'(o_st[0]), 32'd0);

    // Back-pressure: A, B held, C waits upstream
    cycle(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
    check("bp_occ", 32'(o_occ[0]), 32'd2);
    check("bp_rdy", 32'(o_rdy[0]), 32'd0);
    cycle(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush with full skid, then flush while head is consumed
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h33, 1'b0, 1'b1, 1'b0);
    check("flush_sq2", 32'(o_sq[0]), 32'd2);
    cycle(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    check("flush_sq3", 32'(o_sq[0]), 32'd3);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 31) == 0));
    end

    // Saturation of the narrow counter, then clear while still stalling
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    check("sat_stall15", 32'(o_st[2]), 32'd15);
    cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b1);
    check("sat_clr", 32'(o_st[2]), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
